// File: rtl/prog_mem_if.sv
// Program-memory bus: CPU fetch port plus the loader's valid/ready word stream.
// The slave modport is the program memory; the master is the CPU/loader side.
interface prog_mem_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] addr;
    logic [3:0]        opecode;
    logic [3:0]        imm;
    logic              load_req;
    logic              ld_valid;
    logic [7:0]        ld_data;
    logic              ld_ready;
    logic              ld_full;
    logic              cpu_n_rst;

    modport slave (
        input  addr,
        input  load_req,
        input  ld_valid,
        input  ld_data,
        output opecode,
        output imm,
        output ld_ready,
        output ld_full,
        output cpu_n_rst
    );

    modport master (
        output addr,
        output load_req,
        output ld_valid,
        output ld_data,
        input  opecode,
        input  imm,
        input  ld_ready,
        input  ld_full,
        input  cpu_n_rst
    );
endinterface

// File: rtl/prog_mem.sv
// Loadable instruction memory: a loader streams words in while the CPU is held
// in reset, then the CPU is released and fetches with zero-latency reads.
module prog_mem #(
    parameter int ADDR_W   = 4,
    parameter int RST_HOLD = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    prog_mem_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    localparam logic [1:0] RUN  = 2'd3;

    localparam logic [3:0] HOLD_LAST = 4'(RST_HOLD - 1);

    if (RST_HOLD < 1 || RST_HOLD > 15) begin : g_bad_hold
        $error("prog_mem: RST_HOLD must be in 1..15");
    end

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [ADDR_W-1:0] wptr;
    logic              ld_full;
    logic              ld_ready;
    logic              accept;
    logic [3:0]        hold_cnt;
    logic              cpu_run;
    logic              load_entry;
    logic [7:0]        mem [DEPTH];

    assign ld_ready   = (state == LOAD) && !ld_full;
    assign accept     = bus.ld_valid && ld_ready;
    assign load_entry = (state != LOAD) && (state_next == LOAD);

    // load_req wins over the hold counter so a reload can restart at any point.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.load_req) state_next = LOAD;
            LOAD: if (!bus.load_req) state_next = HOLD;
            HOLD: begin
                if (bus.load_req)
                    state_next = LOAD;
                else if (hold_cnt == HOLD_LAST)
                    state_next = RUN;
            end
            RUN:  if (bus.load_req) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            hold_cnt <= 4'd0;
            cpu_run  <= 1'b0;
        end else begin
            state   <= state_next;
            cpu_run <= (state_next == RUN);
            if (state == HOLD && state_next == HOLD)
                hold_cnt <= hold_cnt + 4'd1;
            else
                hold_cnt <= 4'd0;
        end
    end

    // Write pointer, full flag and storage; writes only happen through accept,
    // which is impossible outside LOAD.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr    <= '0;
            ld_full <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= 8'h00;
        end else if (load_entry) begin
            wptr    <= '0;
            ld_full <= 1'b0;
        end else if (accept) begin
            mem[wptr] <= bus.ld_data;
            wptr      <= wptr + ADDR_W'(1);
            if (wptr == '1)
                ld_full <= 1'b1;
        end
    end

    assign {bus.opecode, bus.imm} = (state == RUN) ? mem[bus.addr] : 8'h00;
    assign bus.ld_ready  = ld_ready;
    assign bus.ld_full   = ld_full;
    assign bus.cpu_n_rst = cpu_run;
endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: basic load/run, full load, early drop,
// partial reload and mid-load reset.
module tb_prog_mem;
    logic clk;
    logic n_rst;
    int   n_checks;
    int   n_errors;

    prog_mem_if #(.ADDR_W(4)) bus ();

    prog_mem #(.ADDR_W(4), .RST_HOLD(2)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic read_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        bus.addr = a;
        #1;
        check(tag, {24'h0, bus.opecode, bus.imm}, {24'h0, exp});
    endtask

    function automatic logic [7:0] full_word(input int i);
        return {4'(15 - i), 4'(i)};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_rst        = 1'b0;
        bus.addr     = '0;
        bus.load_req = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = 8'h00;
        tick(2);
        check("rst_cpu_n_rst", 32'(bus.cpu_n_rst), 0);
        check("rst_ld_ready",  32'(bus.ld_ready),  0);
        check("rst_ld_full",   32'(bus.ld_full),   0);
        check("rst_instr",     {24'h0, bus.opecode, bus.imm}, 0);

        // Idle after release
        n_rst = 1'b1;
        tick(10);
        check("idle_cpu_n_rst", 32'(bus.cpu_n_rst), 0);
        check("idle_ld_ready",  32'(bus.ld_ready),  0);
        check("idle_instr",     {24'h0, bus.opecode, bus.imm}, 0);

        // Three-word load
        bus.load_req = 1'b1;
        tick();
        check("load_ld_ready", 32'(bus.ld_ready), 1);
        bus.ld_valid = 1'b1;
        bus.ld_data = 8'h35; tick();
        bus.ld_data = 8'h21; tick();
        bus.ld_data = 8'h90; tick();
        bus.ld_valid = 1'b0;
        bus.load_req = 1'b0;
        tick();
        check("hold1_cpu_n_rst", 32'(bus.cpu_n_rst), 0);
        check("hold1_ld_ready",  32'(bus.ld_ready),  0);
        tick();
        check("hold2_cpu_n_rst", 32'(bus.cpu_n_rst), 0);
        tick();
        check("run_cpu_n_rst", 32'(bus.cpu_n_rst), 1);
        read_chk("b3_a0", 4'd0, 8'h35);
        read_chk("b3_a1", 4'd1, 8'h21);
        read_chk("b3_a2", 4'd2, 8'h90);
        read_chk("b3_a3", 4'd3, 8'h00);

        // Full 16-word load, then overflow attempt
        bus.load_req = 1'b1;
        tick();
        check("reload_cpu_n_rst", 32'(bus.cpu_n_rst), 0);
        read_chk("reload_instr", 4'd0, 8'h00);
        bus.ld_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 15)
                check("full_before_last", 32'(bus.ld_full), 0);
            bus.ld_data = full_word(i);
            tick();
        end
        check("full_ld_full",  32'(bus.ld_full),  1);
        check("full_ld_ready", 32'(bus.ld_ready), 0);
        bus.ld_data = 8'hFF;
        tick(2);
        bus.ld_valid = 1'b0;
        bus.load_req = 1'b0;
        tick(3);
        check("full_run", 32'(bus.cpu_n_rst), 1);
        for (int i = 0; i < 16; i++)
            read_chk($sformatf("full_a%0d", i), 4'(i), full_word(i));

        // load_req dropped on the second handshake edge
        bus.load_req = 1'b1;
        tick();
        check("drop_ld_full_clr", 32'(bus.ld_full),  0);
        check("drop_ld_ready",    32'(bus.ld_ready), 1);
        bus.ld_valid = 1'b1;
        bus.ld_data = 8'hA1; tick();
        bus.ld_data = 8'hB2; bus.load_req = 1'b0; tick();
        bus.ld_valid = 1'b0;
        check("drop_hold_ready", 32'(bus.ld_ready),  0);
        check("drop_hold1",      32'(bus.cpu_n_rst), 0);
        tick();
        check("drop_hold2", 32'(bus.cpu_n_rst), 0);
        tick();
        check("drop_run", 32'(bus.cpu_n_rst), 1);
        read_chk("drop_a0", 4'd0, 8'hA1);
        read_chk("drop_a1", 4'd1, 8'hB2);
        read_chk("drop_a2", 4'd2, full_word(2));

        // Partial reload of address 0 from RUN
        bus.addr = 4'd0;
        bus.load_req = 1'b1;
        tick();
        check("part_cpu_n_rst", 32'(bus.cpu_n_rst), 0);
        read_chk("part_load_instr", 4'd1, 8'h00);
        bus.ld_valid = 1'b1;
        bus.ld_data = 8'h71; tick();
        bus.ld_valid = 1'b0;
        bus.load_req = 1'b0;
        tick(3);
        check("part_run", 32'(bus.cpu_n_rst), 1);
        read_chk("part_a0", 4'd0, 8'h71);
        read_chk("part_a1", 4'd1, 8'hB2);
        read_chk("part_a2", 4'd2, full_word(2));

        // Reset pulse in the middle of a load stream
        bus.load_req = 1'b1;
        tick();
        bus.ld_valid = 1'b1;
        bus.ld_data = 8'h55; tick();
        bus.ld_data = 8'h66;
        n_rst = 1'b0;
        #2;
        check("mid_rst_cpu_n_rst", 32'(bus.cpu_n_rst), 0);
        check("mid_rst_ld_ready",  32'(bus.ld_ready),  0);
        check("mid_rst_ld_full",   32'(bus.ld_full),   0);
        read_chk("mid_rst_instr", 4'd0, 8'h00);
        tick();
        bus.ld_valid = 1'b0;
        bus.load_req = 1'b0;
        n_rst = 1'b1;
        tick(2);
        check("post_rst_idle", 32'(bus.cpu_n_rst), 0);
        bus.load_req = 1'b1; tick();
        bus.load_req = 1'b0; tick(3);
        check("empty_run", 32'(bus.cpu_n_rst), 1);
        for (int i = 0; i < 16; i++)
            read_chk($sformatf("cleared_a%0d", i), 4'(i), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/prog_mem.md
PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, instruction address width; depth = 2^ADDR_W words.
REQ-002 SHALL have parameter RST_HOLD, default 2, cycles cpu_n_rst is held low after a load ends; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port n_rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port addr  input  ADDR_W  CPU fetch address.
REQ-006 SHALL have port opecode  output  4  instruction opcode to the CPU.
REQ-007 SHALL have port imm  output  4  instruction immediate to the CPU.
REQ-008 SHALL have port load_req  input  1  level request to enter or remain in program-load mode.
REQ-009 SHALL have port ld_valid  input  1  loader word valid.
REQ-010 SHALL have port ld_data  input  8  loader word: [7:4] opcode, [3:0] immediate.
REQ-011 SHALL have port ld_ready  output  1  block accepts a word this cycle.
REQ-012 SHALL have port ld_full  output  1  all 2^ADDR_W words written since the load began.
REQ-013 SHALL have port cpu_n_rst  output  1  active-low reset for the CPU; high only while running.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, HOLD, RUN.
REQ-015 SHALL go IDLE->LOAD when load_req=1; otherwise remain in IDLE.
REQ-016 SHALL clear the write pointer and ld_full to 0 on every entry into LOAD.
REQ-017 SHALL drive ld_ready=1 in LOAD while ld_full=0; ld_ready=0 in all other states and cycles.
REQ-018 SHALL write ld_data to mem[wptr] and increment wptr when ld_valid&&ld_ready at a rising edge; there is one word per accepting cycle and no bubbles.
REQ-019 SHALL set ld_full=1 on the edge that accepts word 2^ADDR_W-1; wptr wraps to 0 and further ld_valid is ignored, with no overwrite.
REQ-020 SHALL go LOAD->HOLD when load_req=0; a handshake completing on that same edge SHALL still be written.
REQ-021 SHALL stay in HOLD for exactly RST_HOLD cycles (internal counter), then enter RUN.
REQ-022 SHALL go HOLD->LOAD if load_req=1 during HOLD, taking priority over the counter expiring.
REQ-023 SHALL go RUN->LOAD when load_req=1; cpu_n_rst falls on that same edge.
REQ-024 SHALL drive cpu_n_rst from a flop: 1 exactly in cycles where state=RUN, 0 otherwise.
REQ-025 SHALL drive {opecode,imm}=mem[addr] combinationally (zero-latency read) while state=RUN, and 4'h0/4'h0 in all other states.
REQ-026 SHALL retain memory contents across loads; words not rewritten in a partial load keep old values.
REQ-027 SHALL NOT permit memory writes outside LOAD.

Reset
REQ-028 SHALL, on n_rst=0, asynchronously force state=IDLE, all mem words=8'h00, wptr=0, HOLD counter=0, ld_full=0, ld_ready=0, cpu_n_rst=0, opecode=0, imm=0.
REQ-029 SHALL, on reset mid-LOAD or mid-RUN, discard the in-flight handshake and leave no partial write.
REQ-030 SHALL leave IDLE only on the first rising edge after n_rst=1 with load_req=1.

Verification
REQ-031 Reset release, load_req=0 for 10 cycles -> state IDLE, cpu_n_rst=0, opecode=imm=0, ld_ready=0.
REQ-032 load_req=1; stream 3 words 8'h35,8'h21,8'h90 back-to-back; load_req=0 -> HOLD for 2 cycles, then cpu_n_rst=1; addr=0,1,2 gives opecode/imm 3/5, 2/1, 9/0; addr=3 gives 0/0.
REQ-033 Load 16 consecutive words, then assert ld_valid with 8'hFF -> ld_full=1, ld_ready=0, mem[0] unchanged; all 16 words read back correctly in RUN.
REQ-034 Drop load_req on the same edge as the 2nd handshake -> word 1 written, HOLD entered, RUN after RST_HOLD cycles.
REQ-035 In RUN, assert load_req -> cpu_n_rst=0 the next edge; opecode=imm=0 while in LOAD; reload only addr 0 with 8'h71 -> after RUN, addr 0 gives 7/1 and addr 1..2 keep their prior values.
REQ-036 Pulse n_rst low mid-stream during LOAD -> all outputs are their reset values immediately, and every address reads 0 after the next load with zero words.
